// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin front end that lets four requesters share
// one combinational ALU. Operations are accepted one at a time. The block
// holds the operands on the ALU for one settle cycle, then registers the
// result and returns it as a single-cycle response tagged with the
// requester index.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req_valid,
  input  logic [4*WIDTH-1:0] req_a,
  input  logic [4*WIDTH-1:0] req_b,
  input  logic [4*OPW-1:0]   req_op,
  output logic [3:0]         req_ready,
  output logic [WIDTH-1:0]   alu_x,
  output logic [WIDTH-1:0]   alu_y,
  output logic [OPW-1:0]     alu_op,
  input  logic [WIDTH-1:0]   alu_z,
  output logic               rsp_valid,
  output logic [1:0]         rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_ptr;
  logic [1:0]       r_id;
  logic [WIDTH-1:0] r_alu_x;
  logic [WIDTH-1:0] r_alu_y;
  logic [OPW-1:0]   r_alu_op;
  logic [WIDTH-1:0] r_rsp_data;
  logic [1:0]       r_rsp_id;

  logic [3:0]       w_rot;
  logic [1:0]       w_off;
  logic [1:0]       w_gidx;
  logic             w_any;
  logic             w_accept;
  logic [WIDTH-1:0] w_a_arr  [4];
  logic [WIDTH-1:0] w_b_arr  [4];
  logic [OPW-1:0]   w_op_arr [4];

  // Unpack the flat request buses. Also rotate req_valid so that bit 0 is
  // the requester currently holding top priority.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_req
      assign w_a_arr[gi]  = req_a[gi*WIDTH +: WIDTH];
      assign w_b_arr[gi]  = req_b[gi*WIDTH +: WIDTH];
      assign w_op_arr[gi] = req_op[gi*OPW +: OPW];
      assign w_rot[gi]    = req_valid[r_ptr + 2'(gi)];
    end
  endgenerate

  // Find the first pending request at or after the pointer. The 2-bit add
  // provides the 3 -> 0 wrap.
  always_comb begin
    w_any = |w_rot;
    w_off = 2'd3;
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
    w_gidx = r_ptr + w_off;
  end

  // Next-state and grant logic. The grant is suppressed while reset is
  // held, because the state register is forced to IDLE at that time.
  always_comb begin
    w_state_next = r_state;
    req_ready    = 4'b0000;
    case (r_state)
      ST_IDLE: begin
        if (w_any && !rst) begin
          req_ready    = 4'b0001 << w_gidx;
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: w_state_next = ST_RESP;
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    w_accept = |(req_valid & req_ready);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Datapath: capture operands on accept, capture the result after the
  // settle cycle, and advance the fairness pointer once the response is sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= 2'd0;
      r_id       <= 2'd0;
      r_alu_x    <= '0;
      r_alu_y    <= '0;
      r_alu_op   <= '0;
      r_rsp_data <= '0;
      r_rsp_id   <= 2'd0;
    end else begin
      if (w_accept) begin
        r_alu_x  <= w_a_arr[w_gidx];
        r_alu_y  <= w_b_arr[w_gidx];
        r_alu_op <= w_op_arr[w_gidx];
        r_id     <= w_gidx;
      end
      if (r_state == ST_EXEC) begin
        r_rsp_data <= alu_z;
        r_rsp_id   <= r_id;
      end
      if (r_state == ST_RESP) begin
        r_ptr <= r_id + 2'd1;
      end
    end
  end

  assign alu_x     = r_alu_x;
  assign alu_y     = r_alu_y;
  assign alu_op    = r_alu_op;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign rsp_valid = (r_state == ST_RESP);
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer that shares one combinational ALU among four requesters. It accepts one operation at a time through a valid/ready handshake and drives the captured operands and opcode onto the shared ALU. After one settle cycle it registers the ALU result and returns it with the requester's ID as a one-cycle response pulse. It sits between the lab's operand sources and the mux-built ALU datapath, and is the only block allowed to drive the ALU inputs.

## Interface
- `WIDTH`, 32, operand and result bit width.
- `OPW`, 4, ALU opcode width.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 4: per-requester request. Bit i belongs to requester i.
- `req_a` in 4*WIDTH: flattened operand A. Requester i uses `[i*WIDTH +: WIDTH]`.
- `req_b` in 4*WIDTH: flattened operand B, packed the same way.
- `req_op` in 4*OPW: flattened opcodes. Requester i uses `[i*OPW +: OPW]`.
- `req_ready` out 4: one-hot grant. It is combinational and can be high only in IDLE.
- `alu_x` out WIDTH: ALU operand A, driven from a register.
- `alu_y` out WIDTH: ALU operand B, driven from a register.
- `alu_op` out OPW: ALU opcode, driven from a register.
- `alu_z` in WIDTH: combinational result from the shared ALU.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_id` out 2: index of the requester being answered.
- `rsp_data` out WIDTH: registered ALU result.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- Three states: IDLE, EXEC and RESP. Encoding is free.
- **IDLE**
  - If no `req_valid` bit is set, `req_ready` = 0 and the block stays in IDLE.
  - Otherwise, grant the first set bit found by scanning upward from pointer `ptr`, wrapping 3 -> 0. `req_ready` is one-hot on that bit.
  - On the clock edge with `req_valid[g] & req_ready[g]`:
    - capture `req_a[g]`, `req_b[g]` and `req_op[g]` into the `alu_x`, `alu_y` and `alu_op` registers;
    - capture `g` as the current ID;
    - move to EXEC.
- **EXEC**
  - `alu_x`, `alu_y` and `alu_op` hold steady while the ALU settles.
  - On the edge, load `rsp_data` <= `alu_z` and `rsp_id` <= ID, then move to RESP.
- **RESP**
  - `rsp_valid` = 1 for exactly this cycle. There is no backpressure.
  - On the edge, set `ptr` <= (ID + 1) mod 4 and move to IDLE.
- `alu_x`, `alu_y` and `alu_op` keep their last values in IDLE and RESP. The ALU inputs change only when a request is accepted.
- `rsp_data` and `rsp_id` hold their values after RESP until the next EXEC.
- Requesters must hold `req_valid` and their operands until granted. Dropping `req_valid` before the grant cancels the request; nothing is recorded.
- Fairness: the requester just served gets the lowest priority in the next arbitration. With all four requesting continuously, grants rotate 0, 1, 2, 3, 0, and so on.
- A requester may re-request in the IDLE cycle right after its own RESP. It is granted only if no higher-priority bit is set.
- No arithmetic is done inside the block. `rsp_data` is bit-exact `alu_z`, with no truncation or extension.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, `ptr` = 0, ID = 0;
  - `alu_x`, `alu_y`, `alu_op`, `rsp_data` and `rsp_id` = 0;
  - `rsp_valid` = 0 and `busy` = 0;
  - `req_ready` = 0 while `rst` is high.
- Handshake at edge T leads to EXEC during cycle T+1 and `rsp_valid` during cycle T+2. Latency is 2 cycles from accept to response.
- Maximum throughput is one operation per 3 cycles. The earliest next accept is at edge T+3.
- `req_ready` depends only on state, `ptr` and `req_valid`. There is no combinational path from `alu_z`.
- If reset is asserted during EXEC or RESP, the in-flight operation is discarded and no `rsp_valid` is produced. After reset releases, the first grant starts from requester 0.
- `busy` = 1 during EXEC and RESP.

## Test plan
The bench models the ALU as `alu_z = alu_x + alu_y` for every opcode.

1. **Single request.** Requester 2 requests with a=5, b=7, op=3.
   - `req_ready` = 4'b0100 in the same cycle.
   - `alu_x`/`alu_y`/`alu_op` = 5/7/3 one cycle later.
   - `rsp_valid` = 1 two cycles after the accept, with `rsp_id` = 2 and `rsp_data` = 12.
2. **All four requesting continuously** from reset, with a = i, b = 100.
   - Grant order is 0, 1, 2, 3, 0.
   - Responses are 100, 101, 102, 103, 100, spaced exactly 3 cycles apart.
3. **Wrap-around.** Serve requester 3, then have requesters 0 and 3 request together.
   - Requester 0 is granted first.
4. **Cancelled request.** Requester 1 raises `req_valid` for one cycle while the block is busy, then drops it.
   - No grant is issued and no response appears for ID 1.
   - `alu_x`, `alu_y` and `alu_op` are unchanged.
5. **Reset mid-operation.** Assert `rst` during EXEC.
   - All outputs return to 0 immediately and no `rsp_valid` pulse occurs.
   - After release, requesters 1 and 0 requesting together grants requester 0 first.
6. **Full-width result.** Requester 0 requests with a = 32'hFFFFFFFF, b = 32'h00000001.
   - `rsp_data` = 32'h00000000. This confirms pass-through with no extension beyond `WIDTH`.
